sequential_divider_16: RTL and testbench
========================================

// Module: sequential_divider_16
// PURPOSE
//  - Multi-cycle unsigned restoring divider. It is the inverse operation of the calculator's 16-bit multiplier.
//  - Consumes the two stored operands (num1 = dividend, num2 = divisor) when the calculator's opcode selects divide.
//  - Drives the quotient/remainder into the answer path that feeds the seven-segment display.
//  - Start/busy/done handshake; one quotient bit resolved per clock.
// PARAMETERS
//  WIDTH     16   operand, quotient and remainder width in bits
//  DZ_QUOT   '1   quotient reported on divide-by-zero (all ones, WIDTH bits)
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      request; sampled only in IDLE or DONE
//  Dividend_in    in   WIDTH  unsigned dividend (num1), latched on accepted start
//  Divisor_in     in   WIDTH  unsigned divisor (num2), latched on accepted start
//  Quotient_out   out  WIDTH  result quotient, held until next result
//  Remainder_out  out  WIDTH  result remainder, held until next result
//  busy           out  1      high while an operation is in progress
//  done           out  1      one-cycle pulse, results valid from this cycle on
//  div_by_zero    out  1      flag for the last result; updated with done
// BEHAVIOUR
//  - Reset values: Quotient_out=0, Remainder_out=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
//  - Reset asserted mid-operation aborts immediately: no done, outputs cleared.
//  - States:
//      IDLE   -> DIVIDE on start && divisor!=0
//      IDLE   -> DONE   on start && divisor==0
//      DIVIDE -> DONE   after WIDTH iterations
//      DONE   -> IDLE, or straight to DIVIDE/DONE if start is high in DONE (back-to-back accepted)
//  - Accept edge E0: latch the divisor D. Load Q=dividend, R=0 (WIDTH+1 bits), counter=WIDTH. busy=1 from E0.
//  - Iteration on edges E1..E16 (WIDTH=16): Rs={R[W-1:0],Q[W-1]}; T=Rs-{1'b0,D}.
//      T>=0 : R=T,  Q={Q[W-2:0],1}
//      T<0  : R=Rs, Q={Q[W-2:0],0}
//    Counter decrements each iteration.
//  - On the final iteration edge (E16): write the final Q/R to the outputs, done=1, busy=0, div_by_zero=0.
//    Latency is exactly WIDTH cycles from the accept edge.
//  - Divide-by-zero: accept edge E0 -> DONE at E0. At E1, done=1, Quotient_out=DZ_QUOT, Remainder_out=dividend, div_by_zero=1.
//    Latency is 1 cycle.
//  - start while busy is ignored. Operands changing while busy do not affect the result.
//  - busy and done are never both high. done is high for exactly one cycle per accepted start.
//  - Outputs are updated only on the done edge; they are stable at all other times.
//  - No signed mode; opcode decoding stays outside this block.
// STRUCTURE
//  - Shared package calc_pkg:
//      div_state_t enum {IDLE, DIVIDE, DONE}
//      CALC_WIDTH = 16
//  - Counter width is $clog2(WIDTH)+1.
//  - Sub-module div_step (combinational): one restoring iteration (R,Q,D) -> (R',Q'), instantiated once.
//  - Top holds the FSM, the operand, counter and output registers.
// TESTING
//  1. 100/7 start at E0 -> done pulse at E16; Q=14, R=2, div_by_zero=0; busy high E0..E15.
//  2. 16'hFFFF/1 -> Q=16'hFFFF, R=0; then 3/10 -> Q=0, R=3.
//  3. 5/0 -> done at E1; Q=16'hFFFF, R=5, div_by_zero=1. Next 9/3 clears the flag: Q=3, R=0.
//  4. start with 50/5 held high through busy, operands changed to 7/7 at E4 -> single done, Q=10, R=0.
//  5. 1000/3 with reset pulsed at E8 -> all outputs 0, no done. Next 1000/3 -> Q=333, R=1 at latency 16.
//  6. start high in the done cycle of 20/6 -> Q=3, R=2 reported, second op 17/4 accepted same edge -> Q=4, R=1 after 16 more cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width and divider FSM states.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } div_state_t;

endpackage

// File: rtl/sequential_divider_16_div_step.sv
// One restoring-division iteration: shift the next dividend bit into R and
// subtract the divisor when it fits.
import calc_pkg::*;

module div_step #(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rs;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        rs    = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        diff  = rs - {1'b0, dvs_i};
        // R stays below D, so the top bit is always clear; folding it in keeps the compare exact
        ge    = rem_i[WIDTH] | (rs >= {1'b0, dvs_i});
        rem_o = ge ? diff : rs;
        quo_o = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/sequential_divider_16.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake;
// one quotient bit per clock, divide-by-zero resolved in a single cycle.
import calc_pkg::*;

module sequential_divider_16 #(
    parameter int unsigned      WIDTH   = CALC_WIDTH,
    parameter logic [WIDTH-1:0] DZ_QUOT = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // DONE without done_q set is the pending divide-by-zero cycle; it is still busy
    always_comb begin
        accept  = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (Divisor_in != '0) ? DIVIDE : DONE;
            DIVIDE:  if (cnt_q == CW'(1)) state_d = DONE;
            DONE: begin
                if (!done_q)     state_d = DONE;
                else if (accept) state_d = (Divisor_in != '0) ? DIVIDE : DONE;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        qout_d = qout_q;
        rout_d = rout_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        if (accept) begin
            dvs_d = Divisor_in;
            quo_d = Dividend_in;
            rem_d = '0;
            cnt_d = CW'(WIDTH);
        end else if (state_q == DIVIDE) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                qout_d = step_quo;
                rout_d = step_rem[WIDTH-1:0];
                dz_d   = 1'b0;
                done_d = 1'b1;
            end
        end else if ((state_q == DONE) && !done_q) begin
            qout_d = DZ_QUOT;
            rout_d = quo_q;
            dz_d   = 1'b1;
            done_d = 1'b1;
        end
    end

    always_comb begin
        Quotient_out  = qout_q;
        Remainder_out = rout_q;
        div_by_zero   = dz_q;
        done          = done_q;
        busy          = (state_q == DIVIDE) || ((state_q == DONE) && !done_q);
    end

endmodule

// File: tb/tb_sequential_divider_16.sv
// Directed bench for sequential_divider_16: latency, handshake, divide-by-zero,
// reset abort and back-to-back operation.
module tb_sequential_divider_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        busy;
    logic        done;
    logic        dz;

    int total = 0;
    int bad = 0;

    sequential_divider_16 #(.WIDTH(16), .DZ_QUOT(16'hFFFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .Dividend_in   (dividend),
        .Divisor_in    (divisor),
        .Quotient_out  (quot),
        .Remainder_out (rem),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (dz)
    );

    always #5 clk = ~clk;

    // Present operands with start, return just after the accept edge E0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges after E0 until done is seen (bounded); 0 means it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({quot, rem, busy, done, dz} !== '0) begin
            bad++;
            $display("FAIL reset_vals: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0", quot, rem, busy, done, dz);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int ok;
        start_op(16'd100, 16'd7);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_e0: got busy=%b done=%b, want 1/0", busy, done);
        end
        ok = 1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) ok = 0;
        end
        total++;
        if (ok != 1) begin
            bad++;
            $display("FAIL basic_busy_window: got busy/done wrong in E1..E15, want busy=1 done=0");
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || quot !== 16'd14 || rem !== 16'd2 || dz !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got done=%b busy=%b q=%0d r=%0d dz=%b, want 1 0 14 2 0", done, busy, quot, rem, dz);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || quot !== 16'd14 || rem !== 16'd2) begin
            bad++;
            $display("FAIL basic_pulse: got done=%b q=%0d r=%0d, want 0 14 2", done, quot, rem);
        end
    endtask

    task automatic test_extremes;
        int lat;
        start_op(16'hFFFF, 16'd1);
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'hFFFF || rem !== 16'd0) begin
            bad++;
            $display("FAIL max_by_one: got lat=%0d q=%h r=%0d, want 16 ffff 0", lat, quot, rem);
        end
        start_op(16'd3, 16'd10);
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'd0 || rem !== 16'd3) begin
            bad++;
            $display("FAIL small_by_big: got lat=%0d q=%0d r=%0d, want 16 0 3", lat, quot, rem);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        start_op(16'd5, 16'd0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL dz_busy_e0: got busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(lat);
        total++;
        if (lat != 1 || quot !== 16'hFFFF || rem !== 16'd5 || dz !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dz_result: got lat=%0d q=%h r=%0d dz=%b busy=%b, want 1 ffff 5 1 0", lat, quot, rem, dz, busy);
        end
        start_op(16'd9, 16'd3);
        total++;
        if (dz !== 1'b1) begin
            bad++;
            $display("FAIL dz_hold: got dz=%b, want 1 until next done", dz);
        end
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'd3 || rem !== 16'd0 || dz !== 1'b0) begin
            bad++;
            $display("FAIL dz_clear: got lat=%0d q=%0d r=%0d dz=%b, want 16 3 0 0", lat, quot, rem, dz);
        end
    endtask

    task automatic test_start_while_busy;
        int dones;
        int first;
        dones = 0;
        first = 0;
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin
                dividend = 16'd7;
                divisor  = 16'd7;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (first == 0) first = i;
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (dones != 1 || first != 16 || quot !== 16'd10 || rem !== 16'd0) begin
            bad++;
            $display("FAIL busy_ignore: got dones=%0d lat=%0d q=%0d r=%0d, want 1 16 10 0", dones, first, quot, rem);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int dones;
        start_op(16'd1000, 16'd3);
        for (int i = 1; i <= 7; i++) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({quot, rem, busy, done, dz} !== '0) begin
            bad++;
            $display("FAIL abort_clear: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0", quot, rem, busy, done, dz);
        end
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles after abort, want 0", dones);
        end
        start_op(16'd1000, 16'd3);
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'd333 || rem !== 16'd1) begin
            bad++;
            $display("FAIL abort_rerun: got lat=%0d q=%0d r=%0d, want 16 333 1", lat, quot, rem);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(16'd20, 16'd6);
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'd3 || rem !== 16'd2) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, want 16 3 2", lat, quot, rem);
        end
        dividend = 16'd17;
        divisor  = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || quot !== 16'd3 || rem !== 16'd2) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b q=%0d r=%0d, want 1 0 3 2", busy, done, quot, rem);
        end
        wait_done(lat);
        total++;
        if (lat != 16 || quot !== 16'd4 || rem !== 16'd1) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, want 16 4 1", lat, quot, rem);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_div_zero;
        test_start_while_busy;
        test_reset_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
